// File: rtl/conv_pkg.sv
// Shared widths, opcodes and FSM encoding for the conversion-unit request arbiter.
package conv_pkg;
    localparam int DATA_W = 32;
    localparam int POS_W  = 5;

    localparam logic OP_FLOAT2FIX = 1'b1;
    localparam logic OP_FIX2FLOAT = 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [POS_W-1:0]  pos;
        logic              op;
    } conv_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, on a tie the one
// that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | rr_last);
    assign grant[1] = valid[1] & (~valid[0] | ~rr_last);
endmodule

// File: rtl/conv_req_arbiter.sv
// Shares one fixed/float conversion unit between two valid/ready requesters,
// one operation outstanding, result captured a fixed LATENCY after issue.
module conv_req_arbiter
    import conv_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [POS_W-1:0]  req0_pos,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [POS_W-1:0]  req1_pos,
    input  logic              req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [DATA_W-1:0] conv_number,
    output logic [POS_W-1:0]  conv_pos,
    output logic              conv_op,
    input  logic [DATA_W-1:0] conv_result,
    output logic              busy
);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       rr_last;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       rsp_hs;
    conv_req_t  req_sel;

    rr_arbiter2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last),
        .grant   (grant)
    );

    // Ready is only offered from IDLE, so a grant there is an acceptance.
    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign accept     = req0_ready | req1_ready;

    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) &&  owner;
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        req_sel = {req0_data, req0_pos, req0_op};
        if (grant[1]) req_sel = {req1_data, req1_pos, req1_op};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_last     <= 1'b1;
            owner       <= 1'b0;
            conv_number <= '0;
            conv_pos    <= '0;
            conv_op     <= 1'b0;
            rsp0_data   <= '0;
            rsp1_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    conv_number <= req_sel.data;
                    conv_pos    <= req_sel.pos;
                    conv_op     <= req_sel.op;
                    owner       <= grant[1];
                    cnt         <= LAT_CNT;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Only the owner's data port is updated; the other keeps its last result.
                    if (cnt == 4'd1) begin
                        if (owner) rsp1_data <= conv_result;
                        else       rsp0_data <= conv_result;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: if (rsp_hs) begin
                    rr_last <= owner;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_req_arbiter.sv
// Scoreboard bench: drivers push expected results (stub returns ~number),
// monitors pop and compare on every response handshake.
module tb_conv_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic        r0v = 0, r1v = 0, r0o = 0, r1o = 0, s0r = 1, s1r = 1;
    logic [31:0] r0d = 0, r1d = 0;
    logic [4:0]  r0p = 0, r1p = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, conv_op, busy;
    logic [31:0] rsp0_data, rsp1_data, conv_number, conv_result;
    logic [4:0]  conv_pos;
    assign conv_result = ~conv_number;

    // LATENCY=4 instance, result driven by the bench
    logic        q0v = 0, qs0r = 1;
    logic [31:0] q0d = 0, q_res = 0;
    logic        q_req0_ready, q_req1_ready, q_rsp0_valid, q_rsp1_valid, q_op, q_busy;
    logic [31:0] q_rsp0_data, q_rsp1_data, q_num;
    logic [4:0]  q_pos;

    conv_req_arbiter #(.LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_data(r0d), .req0_pos(r0p), .req0_op(r0o),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_data(r1d), .req1_pos(r1p), .req1_op(r1o),
        .rsp0_valid(rsp0_valid), .rsp0_ready(s0r), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(s1r), .rsp1_data(rsp1_data),
        .conv_number(conv_number), .conv_pos(conv_pos), .conv_op(conv_op),
        .conv_result(conv_result), .busy(busy)
    );

    conv_req_arbiter #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(q0v), .req0_ready(q_req0_ready), .req0_data(q0d), .req0_pos(5'd0), .req0_op(1'b0),
        .req1_valid(1'b0), .req1_ready(q_req1_ready), .req1_data(32'd0), .req1_pos(5'd0), .req1_op(1'b0),
        .rsp0_valid(q_rsp0_valid), .rsp0_ready(qs0r), .rsp0_data(q_rsp0_data),
        .rsp1_valid(q_rsp1_valid), .rsp1_ready(1'b1), .rsp1_data(q_rsp1_data),
        .conv_number(q_num), .conv_pos(q_pos), .conv_op(q_op),
        .conv_result(q_res), .busy(q_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp0[$], exp1[$], exp4[$];
    logic [31:0] e0, e1, e4;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy && !q_busy) return;
        end
        fail("idle_timeout");
    endtask

    // Response monitors
    always @(negedge clk) begin
        if (rst) begin
            if (rsp0_valid && rsp1_valid) fail("rsp_both_valid");
            if (rsp0_valid && s0r) begin
                if (exp0.size() == 0) fail("rsp0_unexpected");
                else begin e0 = exp0.pop_front(); chk("rsp0_data", rsp0_data, e0); end
            end
            if (rsp1_valid && s1r) begin
                if (exp1.size() == 0) fail("rsp1_unexpected");
                else begin e1 = exp1.pop_front(); chk("rsp1_data", rsp1_data, e1); end
            end
            if (q_rsp0_valid && qs0r) begin
                if (exp4.size() == 0) fail("lat4_rsp_unexpected");
                else begin e4 = exp4.pop_front(); chk("lat4_rsp_data", q_rsp0_data, e4); end
            end
            if (q_rsp1_valid) fail("lat4_rsp1_unexpected");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g[$];
        logic prev0, prev1;

        // Reset state
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, conv_op, conv_pos, conv_number}, 0);
        chk("reset_rsp_data", {rsp0_data, rsp1_data}, 0);
        chk("reset_outs_lat4", {q_busy, q_rsp0_valid, q_op, q_pos, q_num}, 0);
        #2 rst = 1'b1;

        // A: single op, LATENCY=1
        step();
        r0v = 1; r0d = 32'h00010000; r0p = 5'd16; r0o = 1'b0;
        @(negedge clk);
        chk("A_req0_ready", req0_ready, 1);
        exp0.push_back(32'hFFFEFFFF);
        step();
        r0v = 0;
        @(negedge clk);
        chk("A_rsp0_early", rsp0_valid, 0);
        @(negedge clk);
        chk("A_rsp0_valid", rsp0_valid, 1);
        wait_idle();

        // B: both valid after reset, round-robin order and one-cycle readies
        step();
        rst = 0;
        #2 rst = 1;
        r0v = 1; r1v = 1; r0d = 32'hA5A50001; r1d = 32'h5A5A0002;
        prev0 = 0; prev1 = 0;
        for (int cyc = 0; cyc < 60 && g.size() < 4; cyc++) begin
            @(negedge clk);
            chk("B_ready_onehot", req0_ready & req1_ready, 0);
            if (prev0) chk("B_ready0_width", req0_ready, 0);
            if (prev1) chk("B_ready1_width", req1_ready, 0);
            prev0 = req0_ready; prev1 = req1_ready;
            if (req0_ready) begin g.push_back(1'b0); exp0.push_back(~r0d); end
            if (req1_ready) begin g.push_back(1'b1); exp1.push_back(~r1d); end
            step();
            r0d = r0d + 32'h00001111;
            r1d = r1d + 32'h00010000;
        end
        r0v = 0; r1v = 0;
        if (g.size() < 4) fail("B_grant_timeout");
        for (int i = 0; i < 4; i++)
            if (i < g.size()) chk("B_grant_order", g[i], i % 2);
        wait_idle();

        // C: response backpressure with req1 waiting
        step();
        s0r = 0; r0v = 1; r0d = 32'hC0FFEE00;
        @(negedge clk);
        chk("C_req0_ready", req0_ready, 1);
        exp0.push_back(32'h3F0011FF);
        step();
        r0v = 0; r1v = 1; r1d = 32'h00000042; r1p = 5'd3;
        for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
        if (!rsp0_valid) fail("C_rsp0_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("C_rsp0_valid_hold", rsp0_valid, 1);
            chk("C_rsp0_data_hold", rsp0_data, 32'h3F0011FF);
            chk("C_req1_blocked", req1_ready, 0);
        end
        step();
        s0r = 1;
        @(negedge clk);
        chk("C_req1_blocked_hs", req1_ready, 0);
        @(negedge clk);
        chk("C_req1_accept", req1_ready, 1);
        exp1.push_back(32'hFFFFFFBD);
        step();
        r1v = 0;
        wait_idle();

        // D: float->fix operands held from accept through RESP and into IDLE
        step();
        s0r = 0; r0v = 1; r0d = 32'h41000000; r0p = 5'd8; r0o = 1'b1;
        @(negedge clk);
        chk("D_req0_ready", req0_ready, 1);
        exp0.push_back(32'hBEFFFFFF);
        step();
        r0v = 0; r0d = 0; r0p = 0; r0o = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("D_conv_hold", {conv_op, conv_pos, conv_number}, {1'b1, 5'd8, 32'h41000000});
        end
        step();
        s0r = 1;
        wait_idle();
        chk("D_conv_idle", {conv_op, conv_pos, conv_number}, {1'b1, 5'd8, 32'h41000000});

        // E: reset during WAIT drops the op
        step();
        r0v = 1; r0d = 32'h77777777;
        @(posedge clk);
        #2;
        r0v = 0;
        rst = 0;
        #1;
        chk("E_outs_zero", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, conv_op, conv_pos, conv_number}, 0);
        chk("E_rsp_data_zero", {rsp0_data, rsp1_data}, 0);
        @(negedge clk);
        #3 rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("E_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        end
        step();
        r0v = 1; r1v = 1; r0d = 32'h0000FFFF; r1d = 32'h00000001;
        @(negedge clk);
        chk("E_first_grant", {req0_ready, req1_ready}, 2'b10);
        exp0.push_back(32'hFFFF0000);
        step();
        r0v = 0; r1v = 0;
        wait_idle();

        // F: LATENCY=4, result sampled only at E0+4
        step();
        q0v = 1; q0d = 32'h12345678; q_res = 32'hDEAD0000;
        @(negedge clk);
        chk("F_req0_ready", q_req0_ready, 1);
        exp4.push_back(32'hEDCBA987);
        @(posedge clk); #1 q0v = 0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 q_res = ~q_num;
        @(negedge clk);
        chk("F_rsp_early", q_rsp0_valid, 0);
        @(posedge clk); #1 q_res = 32'hBAD0BAD0;
        @(negedge clk);
        chk("F_rsp_valid", q_rsp0_valid, 1);
        wait_idle();

        chk("end_queues_empty", exp0.size() + exp1.size() + exp4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
